// File: rtl/dmem_resp.sv
// Memory-stage responder: turns execute-stage load/store requests into a
// split-transaction SRAM-like access and stalls execute until it completes.
module dmem_resp #(
    parameter int ES_TO_MS_BUS_WD = 103,
    parameter int MS_TO_ES_BUS_WD = 33
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       es_advance,
    output logic [MS_TO_ES_BUS_WD-1:0] ms_to_es_bus,
    output logic                       data_req,
    output logic                       data_wr,
    output logic [1:0]                 data_size,
    output logic [31:0]                data_addr,
    output logic [3:0]                 data_wstrb,
    output logic [31:0]                data_wdata,
    input  logic                       data_addr_ok,
    input  logic                       data_data_ok,
    input  logic [31:0]                data_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic        uns_q, uns_d;
    logic [31:0] result_q, result_d;

    logic [31:0] req_addr, req_src;
    logic [3:0]  req_bw;
    logic        req_uns, req_we, req_rfm;
    logic        is_store, is_load, mem_op;
    logic [1:0]  req_size;
    logic        dcache_ok;
    logic        unused_bits;

    assign req_addr = es_to_ms_bus[102:71];
    assign req_uns  = es_to_ms_bus[70];
    assign req_we   = es_to_ms_bus[69];
    assign req_rfm  = es_to_ms_bus[68];
    assign req_bw   = es_to_ms_bus[67:64];
    assign req_src  = es_to_ms_bus[63:32];
    // pc and bit_width[3] carry no meaning for the memory access
    assign unused_bits = ^{es_to_ms_bus[31:0], req_bw[3]};

    assign is_store = req_we;
    assign is_load  = req_rfm & ~req_we;
    assign mem_op   = is_store | is_load;
    assign req_size = size_dec(req_bw);

    function automatic logic [1:0] size_dec(input logic [3:0] bw);
        if (bw[2])      return 2'd2;
        else if (bw[1]) return 2'd1;
        else if (bw[0]) return 2'd0;
        else            return 2'd2;
    endfunction

    function automatic logic [3:0] lane_wstrb(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    return 4'b0001 << a;
            2'd1:    return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] src);
        case (size)
            2'd0:    return {4{src[7:0]}};
            2'd1:    return {2{src[15:0]}};
            default: return src;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] size,
                                                 input logic [1:0] a, input logic uns);
        logic [31:0] sh;
        sh = 32'd0;
        case (size)
            2'd0: begin
                sh = rdata >> {a, 3'b000};
                return uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            2'd1: begin
                sh = rdata >> {a[1], 4'b0000};
                return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: return rdata;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        wr_d     = wr_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        uns_d    = uns_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                result_d = 32'd0;
                if (mem_op) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    wr_d    = is_store;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    uns_d   = req_uns;
                    wstrb_d = is_store ? lane_wstrb(req_size, req_addr[1:0]) : 4'b0000;
                    wdata_d = is_store ? lane_wdata(req_size, req_src) : 32'd0;
                end
            end
            S_REQ: begin
                if (data_addr_ok) begin
                    req_d = 1'b0;
                    if (data_data_ok) begin
                        state_d  = S_DONE;
                        result_d = wr_q ? 32'd0
                                        : load_extract(data_rdata, size_q, addr_q[1:0], uns_q);
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    state_d  = S_DONE;
                    result_d = wr_q ? 32'd0
                                    : load_extract(data_rdata, size_q, addr_q[1:0], uns_q);
                end
            end
            S_DONE: begin
                // Hold the result until execute retires; never re-issue meanwhile.
                if (es_advance) begin
                    state_d  = S_IDLE;
                    result_d = 32'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= 32'd0;
            wstrb_q  <= 4'd0;
            wdata_q  <= 32'd0;
            uns_q    <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            uns_q    <= uns_d;
            result_q <= result_d;
        end
    end

    assign dcache_ok = (state_q == S_IDLE) ? ~mem_op : (state_q == S_DONE);

    assign ms_to_es_bus = {dcache_ok, result_q};
    assign data_req     = req_q;
    assign data_wr      = wr_q;
    assign data_size    = size_q;
    assign data_addr    = addr_q;
    assign data_wstrb   = wstrb_q;
    assign data_wdata   = wdata_q;

endmodule
